ps2_frame_receiver: RTL

- Receives 11-bit PS/2 device-to-host frames on raw `device_clock`/`device_data` pins and presents them to the scancode-conversion stage of the keyboard controller.
- Frame format: start, 8 data bits LSB first, odd parity, stop.
- Outputs the received byte plus one-cycle `recieved_flag`/`error_flag` strobes.
- Is the `u_Shift_Register` stage instantiated inside `KFPS2KB`.
- Receive-only: never drives the PS/2 lines.

---
 rtl/kfps2kb_pkg.sv | 15 +
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_frame_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/kfps2kb_pkg.sv
// Shared types and sizes for the PS/2 keyboard front end.
package kfps2kb_pkg;

  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_TIMEOUT_W = 16;
  localparam int PS2_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter for one raw PS/2 pin.
// The filtered level only moves after filter_depth consecutive synchronized
// samples disagree with it; both flops and the level come out of reset high.
module ps2_line_filter #(
  parameter int filter_depth = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic filtered
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic [3:0] cnt_q,   cnt_d;

  // Register stage: synchronizer, agreement counter and filtered level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count disagreeing samples; flip the level on the filter_depth-th one.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = 4'd0;
    if (sync2_q != level_q) begin
      if (cnt_q == 4'(filter_depth - 1)) begin
        level_d = sync2_q;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign filtered = level_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Bits are taken on filtered clock falling edges. A good frame
// loads register and pulses recieved_flag; a parity, stop or timeout fault
// pulses error_flag. Both strobes are registered and last one cycle.
// state_dbg exposes the FSM state for observation only.
module ps2_frame_receiver
  import kfps2kb_pkg::*;
#(
  parameter logic [PS2_TIMEOUT_W-1:0] over_time    = 16'd1000,
  parameter int                       filter_depth = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     device_clock,
  input  logic                     device_data,
  output logic [PS2_DATA_BITS-1:0] register,
  output logic                     recieved_flag,
  output logic                     error_flag,
  output ps2_rx_state_t            state_dbg
);

  logic f_clock, f_data, bit_event;

  ps2_line_filter #(.filter_depth(filter_depth)) u_clock_filter (
    .clock(clock), .reset(reset), .raw_in(device_clock), .filtered(f_clock)
  );

  ps2_line_filter #(.filter_depth(filter_depth)) u_data_filter (
    .clock(clock), .reset(reset), .raw_in(device_data), .filtered(f_data)
  );

  ps2_rx_state_t              state_q,    state_d;
  logic                       fclk_prev_q, fclk_prev_d;
  logic [PS2_IDX_W-1:0]       index_q,    index_d;
  logic [PS2_DATA_BITS-1:0]   buf_q,      buf_d;
  logic                       parity_q,   parity_d;
  logic [PS2_TIMEOUT_W-1:0]   cnt_q,      cnt_d;
  logic [PS2_DATA_BITS-1:0]   register_q, register_d;
  logic                       rx_flag_q,  rx_flag_d;
  logic                       err_flag_q, err_flag_d;

  assign bit_event = fclk_prev_q & ~f_clock;

  // State register and all datapath flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fclk_prev_q <= 1'b1;
      index_q     <= '0;
      buf_q       <= '0;
      parity_q    <= 1'b0;
      cnt_q       <= '0;
      register_q  <= '0;
      rx_flag_q   <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fclk_prev_q <= fclk_prev_d;
      index_q     <= index_d;
      buf_q       <= buf_d;
      parity_q    <= parity_d;
      cnt_q       <= cnt_d;
      register_q  <= register_d;
      rx_flag_q   <= rx_flag_d;
      err_flag_q  <= err_flag_d;
    end
  end

  // Next state: frame sequencing, bit capture, frame check and timeout.
  always_comb begin
    state_d     = state_q;
    fclk_prev_d = f_clock;
    index_d     = index_q;
    buf_d       = buf_q;
    parity_d    = parity_q;
    register_d  = register_q;
    rx_flag_d   = 1'b0;
    err_flag_d  = 1'b0;

    // Timeout counter: idle and bit events clear it, otherwise saturating.
    if (bit_event || state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    unique case (state_q)
      IDLE: begin
        // A high bit here is a leftover of an interrupted frame: ignore it.
        if (bit_event && !f_data) begin
          state_d = DATA;
          index_d = '0;
        end
      end
      DATA: begin
        if (bit_event) begin
          buf_d[index_q] = f_data;
          if (index_q == PS2_IDX_W'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_event) begin
          parity_d = f_data;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (bit_event) begin
          state_d = IDLE;
          if (f_data && ((^buf_q) ^ parity_q)) begin
            register_d = buf_q;
            rx_flag_d  = 1'b1;
          end else begin
            err_flag_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; a coincident bit event takes priority.
    if (state_q != IDLE && !bit_event && cnt_q == over_time) begin
      state_d    = IDLE;
      buf_d      = '0;
      err_flag_d = 1'b1;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    register      = register_q;
    recieved_flag = rx_flag_q;
    error_flag    = err_flag_q;
    state_dbg     = state_q;
  end

endmodule
